echo_capture: RTL and testbench

Receive-side companion to the transducer pulser: on the same sync edge that fires the transmit burst, it waits a programmable dead time, then captures a window of ADC echo samples. It decimates them by block averaging and streams the results through a 4-entry FIFO on a valid/ready interface toward the frame packer. Capture parameters are latched per shot, so register writes during a shot never corrupt it.

---
 rtl/echo_capture.sv | 186 ++++++++++++++++++
 tb/tb_echo_capture.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_capture.sv
// echo_capture: sync-triggered echo capture with programmable dead time, block-average
// decimation and a 4-deep valid/ready output FIFO. Define ECHO_CAPTURE_PEAK_EN to build the per-block peak detector.
module echo_capture (
    input  logic        hi_clk,
    input  logic        rst_n,
    input  logic        i_sync,
    input  logic [15:0] i_rx_delay,
    input  logic [11:0] i_rx_len,
    input  logic [2:0]  i_decim,
    input  logic        i_peak_mode,
    input  logic [9:0]  i_adc_data,
    output logic [9:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_overflow
);

    localparam int unsigned ADC_W  = 10;
    localparam int unsigned DLY_W  = 16;
    localparam int unsigned LEN_W  = 12;
    localparam int unsigned DEC_W  = 3;
    localparam int unsigned ACC_W  = 17;
    localparam int unsigned SCNT_W = 7;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;

    typedef struct packed {
        logic             last;
        logic [ADC_W-1:0] data;
    } word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [1:0]         sync_q;
    logic               hi_sync, start;
    logic [DLY_W-1:0]   dly_q, dly_cnt;
    logic [LEN_W-1:0]   len_q, word_cnt;
    logic [DEC_W-1:0]   decim_q;
    logic [SCNT_W-1:0]  samp_cnt, blk_max;
    logic [ACC_W-1:0]   acc, acc_sum, acc_next;
    logic [ADC_W-1:0]   new_data;
    logic               blk_end, last_word;
    logic               emit_v;
    word_t              emit_w;
    word_t              mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow, pop, push, full;

    assign hi_sync   = (sync_q == 2'b01);
    assign start     = hi_sync && (i_rx_len != '0);
    assign blk_max   = SCNT_W'((8'd1 << decim_q) - 8'd1);
    assign blk_end   = (samp_cnt == blk_max);
    assign last_word = (word_cnt == len_q - LEN_W'(1));
    assign acc_sum   = acc + ACC_W'(i_adc_data);

`ifdef ECHO_CAPTURE_PEAK_EN
    logic             peak_q;
    logic [ACC_W-1:0] acc_max;

    assign acc_max  = (ACC_W'(i_adc_data) > acc) ? ACC_W'(i_adc_data) : acc;
    assign acc_next = peak_q ? acc_max : acc_sum;
    assign new_data = peak_q ? acc_max[ADC_W-1:0] : ADC_W'(acc_sum >> decim_q);

    // Peak select is part of the per-shot parameter set
    always_ff @(posedge hi_clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= 1'b0;
        end else if (start) begin
            peak_q <= i_peak_mode;
        end
    end
`else
    logic unused_peak;

    assign unused_peak = i_peak_mode;
    assign acc_next    = acc_sum;
    assign new_data    = ADC_W'(acc_sum >> decim_q);
`endif

    always_ff @(posedge hi_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // A qualifying sync restarts from any state; otherwise walk delay -> capture -> idle
    always_comb begin
        state_n = state;
        if (start) begin
            state_n = (i_rx_delay == '0) ? CAPTURE : DELAY;
        end else begin
            case (state)
                IDLE:    ;
                DELAY:   if (dly_cnt == dly_q - DLY_W'(1)) state_n = CAPTURE;
                CAPTURE: if (blk_end && last_word) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Sync detect, parameter latch, accumulation and word emit register
    always_ff @(posedge hi_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            dly_q    <= '0;
            len_q    <= '0;
            decim_q  <= '0;
            dly_cnt  <= '0;
            samp_cnt <= '0;
            word_cnt <= '0;
            acc      <= '0;
            emit_v   <= 1'b0;
            emit_w   <= '0;
        end else begin
            sync_q <= {sync_q[0], i_sync};
            if (start) begin
                dly_q    <= i_rx_delay;
                len_q    <= i_rx_len;
                decim_q  <= i_decim;
                dly_cnt  <= '0;
                samp_cnt <= '0;
                word_cnt <= '0;
                acc      <= '0;
                emit_v   <= 1'b0;
            end else begin
                emit_v <= 1'b0;
                if (state == DELAY) dly_cnt <= dly_cnt + DLY_W'(1);
                if (state == CAPTURE) begin
                    if (blk_end) begin
                        acc      <= '0;
                        samp_cnt <= '0;
                        word_cnt <= word_cnt + LEN_W'(1);
                        emit_v   <= 1'b1;
                        emit_w   <= '{last: last_word, data: new_data};
                    end else begin
                        acc      <= acc_next;
                        samp_cnt <= samp_cnt + SCNT_W'(1);
                    end
                end
            end
        end
    end

    assign pop  = o_valid && i_ready;
    assign full = (count == CNT_W'(DEPTH));
    assign push = emit_v && (!full || pop);

    // Output FIFO; a word arriving while full with no read is dropped
    always_ff @(posedge hi_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= emit_w;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (emit_v && full && !pop) overflow <= 1'b1;
        end
    end

    assign o_valid    = (count != '0);
    assign o_data     = mem[rd_ptr].data;
    assign o_last     = mem[rd_ptr].last;
    assign o_busy     = (state != IDLE) || emit_v || (count != '0);
    assign o_overflow = overflow;

endmodule

// File: tb/tb_echo_capture.sv
// tb_echo_capture: directed and randomized shots against a sample-history reference model.
module tb_echo_capture;

`ifdef ECHO_CAPTURE_PEAK_EN
    localparam bit PEAK_BUILT = 1'b1;
`else
    localparam bit PEAK_BUILT = 1'b0;
`endif
    localparam int unsigned HIST = 16384;

    logic        hi_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_sync = 1'b0;
    logic [15:0] i_rx_delay = '0;
    logic [11:0] i_rx_len = '0;
    logic [2:0]  i_decim = '0;
    logic        i_peak_mode = 1'b0;
    logic [9:0]  i_adc_data = '0;
    logic [9:0]  o_data;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic        o_last;
    logic        o_busy;
    logic        o_overflow;

    echo_capture dut (
        .hi_clk      (hi_clk),
        .rst_n       (rst_n),
        .i_sync      (i_sync),
        .i_rx_delay  (i_rx_delay),
        .i_rx_len    (i_rx_len),
        .i_decim     (i_decim),
        .i_peak_mode (i_peak_mode),
        .i_adc_data  (i_adc_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_last      (o_last),
        .o_busy      (o_busy),
        .o_overflow  (o_overflow)
    );

    always #5 hi_clk = ~hi_clk;

    int unsigned cyc = 0;
    always @(posedge hi_clk) cyc <= cyc + 1;

    logic [9:0]  adc_hist [HIST];
    logic [9:0]  adc_tab [$];
    int unsigned tab_base = 0;
    int          adc_mode = 0;
    int          ready_mode = 1;
    logic [10:0] got [$];
    int          first_v = -1;
    bit          hold_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [10:0] prev_w = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Advance one cycle, then drive this cycle's ADC sample and ready
    task automatic tick();
        logic [9:0] v;
        @(posedge hi_clk);
        #1;
        case (adc_mode)
            1: v = cyc[9:0];
            2: if (cyc >= tab_base && (cyc - tab_base) < adc_tab.size())
                   v = adc_tab[cyc - tab_base];
               else
                   v = 10'($urandom);
            default: v = 10'($urandom);
        endcase
        i_adc_data = v;
        adc_hist[cyc % HIST] = v;
        i_ready = (ready_mode == 1) ||
                  (ready_mode == 2 && (cyc[0] || $urandom_range(0, 1) == 1));
    endtask

    // Observe transfers and check output stability under backpressure
    always @(negedge hi_clk) begin
        if (hold_en && prev_v && !prev_r)
            check("hold", 32'({o_valid, o_last, o_data}), 32'({1'b1, prev_w}));
        prev_v = o_valid;
        prev_r = i_ready;
        prev_w = {o_last, o_data};
        if (o_valid && i_ready) got.push_back({o_last, o_data});
        if (o_valid && first_v < 0) first_v = int'(cyc);
    end

    // Expected word j of a shot whose sync was seen in cycle s
    function automatic logic [9:0] model_word(input int unsigned s, input int unsigned d,
                                              input int m, input bit pk, input int j);
        int unsigned n, base, sum, mx, v;
        n = 1 << m;
        base = s + 1 + d + int'(j) * n;
        sum = 0;
        mx = 0;
        for (int unsigned k = 0; k < n; k++) begin
            v = adc_hist[(base + k) % HIST];
            sum += v;
            if (v > mx) mx = v;
        end
        return (pk && PEAK_BUILT) ? 10'(mx) : 10'(sum >> m);
    endfunction

    task automatic fire(input int d, input int len, input int m, input int pk,
                        output int unsigned s);
        i_rx_delay  = 16'(d);
        i_rx_len    = 12'(len);
        i_decim     = 3'(m);
        i_peak_mode = 1'(pk);
        i_sync      = 1'b1;
        s = cyc + 1;
        tick();
        i_sync = 1'b0;
        tick();
        i_rx_delay  = 16'($urandom);
        i_rx_len    = 12'($urandom);
        i_decim     = 3'($urandom);
        i_peak_mode = 1'($urandom);
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (got.size() < n) check("timeout", 32'(got.size()), 32'(n));
    endtask

    task automatic check_shot(input string tag, input int unsigned s, input int d, input int m,
                              input bit pk, input int len, input int n);
        for (int j = 0; j < n; j++) begin
            if (j < got.size())
                check(tag, 32'(got[j]), 32'({j == len - 1, model_word(s, d, m, pk, j)}));
        end
    endtask

    initial begin
        int unsigned s, s2;
        int d, m, len, pk;

        repeat (3) tick();
        check("rst_valid", 32'(o_valid), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_last", 32'(o_last), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_ovf", 32'(o_overflow), 0);
        rst_n = 1'b1;
        repeat (2) tick();
        hold_en = 1'b1;

        // Dead time and first-word latency on a ramp
        adc_mode = 1;
        ready_mode = 1;
        got.delete();
        first_v = -1;
        fire(5, 3, 0, 0, s);
        wait_words(3, 40);
        repeat (3) tick();
        check("lat_first_valid", 32'(first_v), 32'(s + 8));
        check("lat_count", 32'(got.size()), 3);
        for (int j = 0; j < 3; j++)
            if (j < got.size())
                check("lat_word", 32'(got[j]), 32'({j == 2, 10'(s + 6 + j)}));
        check("lat_busy", 32'(o_busy), 0);

        // Block averaging with truncation
        adc_mode = 2;
        adc_tab = '{10'd1, 10'd2, 10'd3, 10'd6, 10'd1023, 10'd1023, 10'd1023, 10'd1020};
        tab_base = cyc + 5;
        got.delete();
        fire(3, 2, 2, 0, s);
        wait_words(2, 60);
        repeat (3) tick();
        check("avg_count", 32'(got.size()), 2);
        if (got.size() >= 2) begin
            check("avg_w0", 32'(got[0]), 32'({1'b0, 10'd3}));
            check("avg_w1", 32'(got[1]), 32'({1'b1, 10'd1022}));
        end

        // Peak mode (average when the detector is not built)
        adc_tab = '{10'd5, 10'd900, 10'd7, 10'd3};
        tab_base = cyc + 2;
        got.delete();
        fire(0, 1, 2, 1, s);
        wait_words(1, 40);
        repeat (3) tick();
        if (got.size() >= 1)
            check("peak_word", 32'(got[0]), 32'({1'b1, PEAK_BUILT ? 10'd900 : 10'd228}));

        // Backpressure until overflow, then drain
        adc_mode = 0;
        ready_mode = 0;
        got.delete();
        fire(0, 8, 0, 0, s);
        repeat (20) tick();
        check("ovf_valid", 32'(o_valid), 1);
        check("ovf_flag", 32'(o_overflow), 1);
        check("ovf_busy", 32'(o_busy), 1);
        check("ovf_head", 32'({o_last, o_data}), 32'({1'b0, model_word(s, 0, 0, 0, 0)}));
        check("ovf_none_yet", 32'(got.size()), 0);
        ready_mode = 1;
        wait_words(4, 20);
        repeat (5) tick();
        check("ovf_drained", 32'(got.size()), 4);
        check_shot("ovf_word", s, 0, 0, 0, 8, 4);
        check("ovf_busy_end", 32'(o_busy), 0);
        check("ovf_sticky", 32'(o_overflow), 1);

        // Restart mid-capture discards the old shot
        ready_mode = 0;
        got.delete();
        fire(0, 20, 1, 0, s);
        repeat (12) tick();
        check("rs_pre_valid", 32'(o_valid), 1);
        check("rs_pre_ovf", 32'(o_overflow), 1);
        hold_en = 1'b0;
        fire(0, 2, 0, 0, s2);
        i_ready = 1'b1;
        ready_mode = 1;
        got.delete();
        check("rs_ovf_clear", 32'(o_overflow), 0);
        check("rs_flushed", 32'(o_valid), 0);
        wait_words(2, 20);
        repeat (4) tick();
        hold_en = 1'b1;
        check("rs_count", 32'(got.size()), 2);
        check_shot("rs_word", s2, 0, 0, 0, 2, 2);
        check("rs_busy", 32'(o_busy), 0);

        // Asynchronous reset mid-capture
        hold_en = 1'b0;
        fire(2, 50, 0, 0, s);
        repeat (10) tick();
        check("mid_busy_pre", 32'(o_busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_valid), 0);
        check("mid_rst_data", 32'(o_data), 0);
        check("mid_rst_last", 32'(o_last), 0);
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_ovf", 32'(o_overflow), 0);
        #1 rst_n = 1'b1;
        repeat (2) tick();
        got.delete();
        i_rx_len = '0;
        i_sync = 1'b1;
        tick();
        i_sync = 1'b0;
        repeat (8) begin
            tick();
            check("len0_busy", 32'(o_busy), 0);
        end
        check("len0_valid", 32'(o_valid), 0);
        hold_en = 1'b1;

        // Randomized shots, some with an ignored len=0 sync inside
        for (int t = 0; t < 30; t++) begin
            d = $urandom_range(0, 20);
            m = $urandom_range(0, 3);
            len = $urandom_range(1, 10);
            pk = $urandom_range(0, 1);
            ready_mode = (m == 0) ? 1 : 2;
            got.delete();
            fire(d, len, m, pk, s);
            if (t % 5 == 0) begin
                i_rx_len = '0;
                i_sync = 1'b1;
                tick();
                i_sync = 1'b0;
            end
            wait_words(len, len * (1 << m) * 2 + d + 40);
            repeat (4) tick();
            check("rnd_count", 32'(got.size()), 32'(len));
            check_shot("rnd_word", s, d, m, pk[0], len, len);
            check("rnd_ovf", 32'(o_overflow), 0);
            check("rnd_busy", 32'(o_busy), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
